// File: rtl/mem_pkg.sv
// Shared types and widths for the memory responder.
// Read FSM state encoding, output source select, range helper.
package mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int IDX_W  = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_ARR  = 2'd1,
        SEL_BYP  = 2'd2
    } rd_sel_e;

    function automatic logic in_range(
        input logic [IDX_W-1:0] idx,
        input int               depth
    );
        return int'({{(32-IDX_W){1'b0}}, idx}) < depth;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Read/write bus between an initiator and the memory responder.
// Initiator uses the master modport, responder the slave modport.
interface mem_responder_if
    import mem_pkg::*;
;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              fault;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data, rd_valid, fault
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data, rd_valid, fault
    );

endinterface

// File: rtl/mem_array.sv
// Word storage: synchronous write, registered read on re_i.
// Read is read-first; same-edge forwarding is done by the parent.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [IW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Single write port and single registered read port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: read FSM, write port, sticky fault.
// Option MEM_RESPONDER_X0_ZERO_EN: word 0 reads 0 and ignores writes.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 2
) (
    input logic            clk,
    input logic            rst_n,
    mem_responder_if.slave bus
);

    localparam int IW =
        (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_M1 = 4'(RD_LATENCY - 1);
`ifdef MEM_RESPONDER_X0_ZERO_EN
    localparam logic X0_ZERO = 1'b1;
`else
    localparam logic X0_ZERO = 1'b0;
`endif

    rd_state_e         state_q;
    rd_sel_e           sel_q;
    logic [3:0]        cnt_q;
    logic [IDX_W-1:0]  addr_q;
    logic              rd_valid_q;
    logic              fault_q;
    logic [DATA_W-1:0] byp_q;
    logic [DATA_W-1:0] arr_data;

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             rd_ok;
    logic             wr_ok;
    logic             wr_go;
    logic             rd_fire;
    logic             byp_hit;
    logic             addr_zero;

    assign rd_idx    = bus.rd_addr[ADDR_W-1:2];
    assign wr_idx    = bus.wr_addr[ADDR_W-1:2];
    assign rd_ok     = in_range(rd_idx, DEPTH_WORDS);
    assign wr_ok     = in_range(wr_idx, DEPTH_WORDS);
    assign wr_go     = bus.wr_en && rst_n && wr_ok
                     && !(X0_ZERO && wr_idx == '0);
    assign rd_fire   = rst_n && state_q == WAIT
                     && cnt_q == '0;
    assign byp_hit   = bus.wr_en && wr_idx == addr_q;
    assign addr_zero = !in_range(addr_q, DEPTH_WORDS)
                     || (X0_ZERO && addr_q == '0);

    mem_array #(.DEPTH(DEPTH_WORDS)) u_mem (
        .clk     (clk),
        .we_i    (wr_go),
        .waddr_i (wr_idx[IW-1:0]),
        .wdata_i (bus.wr_data),
        .re_i    (rd_fire),
        .raddr_i (addr_q[IW-1:0]),
        .rdata_o (arr_data)
    );

    // Read FSM with latency counter, output source select and fault.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= SEL_ZERO;
            cnt_q      <= '0;
            addr_q     <= '0;
            rd_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            byp_q      <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            if (bus.wr_en
                && (bus.wr_addr[1:0] != 2'b00 || !wr_ok)) begin
                fault_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (bus.rd_en) begin
                        addr_q  <= rd_idx;
                        cnt_q   <= LAT_M1;
                        state_q <= WAIT;
                        if (bus.rd_addr[1:0] != 2'b00 || !rd_ok) begin
                            fault_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        rd_valid_q <= 1'b1;
                        state_q    <= DONE;
                        if (addr_zero) begin
                            sel_q <= SEL_ZERO;
                        end else if (byp_hit) begin
                            sel_q <= SEL_BYP;
                            byp_q <= bus.wr_data;
                        end else begin
                            sel_q <= SEL_ARR;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    if (!bus.rd_en) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output data source is chosen once per read and held.
    always_comb begin
        bus.rd_data = '0;
        unique case (sel_q)
            SEL_ARR: bus.rd_data = arr_data;
            SEL_BYP: bus.rd_data = byp_q;
            default: bus.rd_data = '0;
        endcase
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.fault    = fault_q;

endmodule
